decoder_sweep_ctrl: RTL

// - Sequencer for the decoder-tree function evaluator (one 2x4 decoder feeding four 2x4 decoders, with a minterm NAND).
// - On start: enables the evaluator, steps ABCD through all 16 codes, 0 to 15.
// - Samples F for each code into a 16-bit truth table, then compares it against an expected minterm mask.
// - Sits between the test/control logic and the combinational evaluator. Gives built-in exhaustive self-check.

---
 rtl/decoder_sweep_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/decoder_sweep_ctrl.sv
// rtl/decoder_sweep_ctrl.sv - exhaustive ABCD sweep sequencer for the decoder-tree evaluator
// Drives codes 0..15, captures F into a truth table and compares it with EXPECT_MASK.
module decoder_sweep_ctrl #(
   parameter logic [15:0] EXPECT_MASK = 16'h0DD0,
   parameter int          SETTLE      = 2,
   parameter bit          F_INV       = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        f_in,
   output logic        dec_en,
   output logic [3:0]  dec_abcd,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] table_out,
   output logic        fail_valid,
   output logic [3:0]  fail_idx
);

   typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, CHECK, DONE} state_t;

   localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

   state_t      state;
   logic [3:0]  idx;
   logic [3:0]  cnt;
   logic [15:0] diff;

   assign diff = table_out ^ EXPECT_MASK;

   // Lowest mismatching code wins, so scan from the top down.
   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= 4'd0;
         cnt        <= 4'd0;
         dec_en     <= 1'b0;
         dec_abcd   <= 4'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         table_out  <= 16'd0;
         fail_valid <= 1'b0;
         fail_idx   <= 4'd0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && abort) begin
            // Partial table is kept for debug; pass/fail stay as cleared at start.
            state    <= IDLE;
            dec_en   <= 1'b0;
            dec_abcd <= 4'd0;
            busy     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state      <= DRIVE;
                     idx        <= 4'd0;
                     cnt        <= SETTLE_M1;
                     table_out  <= 16'd0;
                     pass       <= 1'b0;
                     fail_valid <= 1'b0;
                     fail_idx   <= 4'd0;
                     busy       <= 1'b1;
                     dec_en     <= 1'b1;
                     dec_abcd   <= 4'd0;
                  end
               end
               DRIVE: begin
                  if (cnt == 4'd0) state <= SAMPLE;
                  else             cnt   <= cnt - 4'd1;
               end
               SAMPLE: begin
                  table_out[idx] <= f_in ^ F_INV;
                  if (idx == 4'd15) begin
                     state  <= CHECK;
                     dec_en <= 1'b0;
                  end else begin
                     idx      <= idx + 4'd1;
                     dec_abcd <= idx + 4'd1;
                     cnt      <= SETTLE_M1;
                     state    <= DRIVE;
                  end
               end
               CHECK: begin
                  pass       <= (table_out == EXPECT_MASK);
                  fail_valid <= |diff;
                  fail_idx   <= lowest_set(diff);
                  done       <= 1'b1;
                  state      <= DONE;
               end
               DONE: begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  dec_abcd <= 4'd0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
